// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (CPU, DMA) arbiter and sequencer in front of a
// single-ported memory whose read data is registered one edge after the
// address is presented. Each access is IDLE -> ISSUE -> CAPTURE, and the
// master sees a one-cycle ack in CAPTURE.
//
// Ports
//   ph1, reset_b                 clock (posedge) and async active-low reset
//   cpu_req/we/addr/wdata        CPU request; req is held until cpu_ack
//   cpu_ack/rdata/err            CPU completion pulse, read data, error flag
//   dma_*                        same as cpu_* for the DMA/loader master
//   mem_address/rw_sel/wdata     memory port (rw_sel: 1=read, 0=write)
//   mem_wdata_oe                 drive enable for the shared data bus
//   mem_rdata                    registered memory read data
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a request; arbitrate and latch the winner
// ST_ISSUE   | address (and write data for legal writes) on the memory port
// ST_CAPTURE | memory data valid; ack the selected master, latch rdata/err

module mem_arbiter #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter logic [3:0]  RAM_PAGE = 4'h0,
   parameter logic [3:0]  ROM_PAGE = 4'hF
) (
   input  logic              ph1,
   input  logic              reset_b,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_rw_sel,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wdata_oe,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                sel_dma_q, sel_dma_d;
   logic                last_dma_q, last_dma_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   cpu_rdata_q, dma_rdata_q;
   logic                cpu_err_q, dma_err_q;

   logic                grant_dma;
   logic [3:0]          page;
   logic                ram_hit, rom_hit, legal_wr, acc_err, capture;

   assign page     = addr_q[ADDR_W-1 -: 4];
   assign ram_hit  = (page == RAM_PAGE);
   assign rom_hit  = (page == ROM_PAGE);
   assign legal_wr = we_q && ram_hit;
   assign acc_err  = (we_q && !ram_hit) || (!ram_hit && !rom_hit);
   assign capture  = (state_q == ST_CAPTURE);

   always_ff @(posedge ph1 or negedge reset_b) begin
      if (!reset_b) begin
         state_q     <= ST_IDLE;
         sel_dma_q   <= 1'b0;
         last_dma_q  <= 1'b1;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         cpu_err_q   <= 1'b0;
         dma_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_dma_q  <= sel_dma_d;
         last_dma_q <= last_dma_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         if (cpu_ack) begin
            if (!we_q) cpu_rdata_q <= mem_rdata;
            cpu_err_q <= acc_err;
         end
         if (dma_ack) begin
            if (!we_q) dma_rdata_q <= mem_rdata;
            dma_err_q <= acc_err;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_dma_d  = sel_dma_q;
      last_dma_d = last_dma_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      // On a tie the master that did not win last time gets the grant.
      grant_dma  = dma_req && (!cpu_req || !last_dma_q);
      case (state_q)
         ST_IDLE: begin
            if (cpu_req || dma_req) begin
               state_d    = ST_ISSUE;
               sel_dma_d  = grant_dma;
               last_dma_d = grant_dma;
               addr_d     = grant_dma ? dma_addr  : cpu_addr;
               we_d       = grant_dma ? dma_we    : cpu_we;
               wdata_d    = grant_dma ? dma_wdata : cpu_wdata;
            end
         end
         ST_ISSUE:   state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Memory port is decoded from registered state only, so no req reaches it.
   assign mem_address  = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_wdata_oe = (state_q == ST_ISSUE) && legal_wr;
   assign mem_rw_sel   = !mem_wdata_oe;

   // Read data and error are passed straight through during the ack cycle,
   // then held from the registers until the next access for that master.
   assign cpu_ack   = capture && !sel_dma_q;
   assign dma_ack   = capture &&  sel_dma_q;
   assign cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : cpu_rdata_q;
   assign dma_rdata = (dma_ack && !we_q) ? mem_rdata : dma_rdata_q;
   assign cpu_err   = cpu_ack ? acc_err : cpu_err_q;
   assign dma_err   = dma_ack ? acc_err : dma_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        ph1 = 1'b0;
   logic        reset_b;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack, cpu_err;
   logic [7:0]  cpu_rdata;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [15:0] dma_addr = '0;
   logic [7:0]  dma_wdata = '0;
   logic        dma_ack, dma_err;
   logic [7:0]  dma_rdata;
   logic [15:0] mem_address;
   logic        mem_rw_sel, mem_wdata_oe;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;

   mem_arbiter dut (
      .ph1(ph1), .reset_b(reset_b),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
      .mem_address(mem_address), .mem_rw_sel(mem_rw_sel), .mem_wdata(mem_wdata),
      .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
   );

   always #5 ph1 = ~ph1;

   int cyc = 0;
   always @(posedge ph1) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rom_val(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5C;
   endfunction

   // Physical memory: registered read, RAM page writable, ROM fixed, rest reads 0.
   logic [7:0] phys_ram [4096];
   logic [7:0] ref_ram  [4096];

   always @(posedge ph1) begin
      if (!mem_rw_sel && mem_wdata_oe && mem_address[15:12] == 4'h0)
         phys_ram[mem_address[11:0]] <= mem_wdata;
      case (mem_address[15:12])
         4'h0:    mem_rdata <= phys_ram[mem_address[11:0]];
         4'hF:    mem_rdata <= rom_val(mem_address);
         default: mem_rdata <= 8'h00;
      endcase
   end

   // Scoreboard: one queue of issued requests per master.
   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } req_t;

   req_t q_cpu[$];
   req_t q_dma[$];
   int   ack_m[$];
   int   ack_c[$];

   logic [7:0] hold_rd  [2];
   logic       hold_err [2];
   int         lg_model;

   initial begin : monitor
      logic [1:0] h0, h1, h2;
      logic       ack, er;
      logic [7:0] rd;
      req_t       r;
      bit         have;
      logic [7:0] exp_rd;
      logic       exp_err;
      h0 = '0; h1 = '0; h2 = '0;
      hold_rd[0] = '0; hold_rd[1] = '0; hold_err[0] = 1'b0; hold_err[1] = 1'b0;
      lg_model = 1;
      forever begin
         @(negedge ph1);
         if (!reset_b) begin
            hold_rd[0] = '0; hold_rd[1] = '0;
            hold_err[0] = 1'b0; hold_err[1] = 1'b0;
            lg_model = 1;
            h0 = '0; h1 = '0; h2 = '0;
         end else begin
            h2 = h1; h1 = h0; h0 = {dma_req, cpu_req};
            if (cpu_ack || dma_ack) chk("ack_exclusive", 32'(cpu_ack & dma_ack), 0);
            if (!mem_rw_sel) begin
               chk("wr_only_ram_page", 32'(mem_address[15:12]), 0);
               chk("wr_oe", 32'(mem_wdata_oe), 1);
            end
            if (mem_wdata_oe) chk("oe_implies_write", 32'(mem_rw_sel), 0);
            for (int m = 0; m < 2; m++) begin
               ack = (m == 0) ? cpu_ack   : dma_ack;
               rd  = (m == 0) ? cpu_rdata : dma_rdata;
               er  = (m == 0) ? cpu_err   : dma_err;
               if (ack) begin
                  have = 0;
                  if (m == 0 && q_cpu.size() > 0) begin r = q_cpu.pop_front(); have = 1; end
                  if (m == 1 && q_dma.size() > 0) begin r = q_dma.pop_front(); have = 1; end
                  if (!have) begin
                     chk($sformatf("unexpected_ack_m%0d", m), 1, 0);
                  end else begin
                     exp_err = (r.we && r.addr[15:12] != 4'h0) ||
                               (r.addr[15:12] != 4'h0 && r.addr[15:12] != 4'hF);
                     if (r.we)                        exp_rd = hold_rd[m];
                     else if (r.addr[15:12] == 4'h0)  exp_rd = ref_ram[r.addr[11:0]];
                     else if (r.addr[15:12] == 4'hF)  exp_rd = rom_val(r.addr);
                     else                             exp_rd = 8'h00;
                     chk($sformatf("rdata_m%0d_a%04h", m, r.addr), 32'(rd), 32'(exp_rd));
                     chk($sformatf("err_m%0d_a%04h", m, r.addr), 32'(er), 32'(exp_err));
                     chk($sformatf("req_seen_m%0d", m), 32'(h2[m]), 1);
                     if (h2 == 2'b11) chk("round_robin_tie", m, 1 - lg_model);
                     lg_model = m;
                     if (r.we && r.addr[15:12] == 4'h0) ref_ram[r.addr[11:0]] = r.wdata;
                     hold_rd[m]  = exp_rd;
                     hold_err[m] = exp_err;
                  end
                  ack_m.push_back(m);
                  ack_c.push_back(cyc);
               end else begin
                  chk($sformatf("hold_rdata_m%0d", m), 32'(rd), 32'(hold_rd[m]));
                  chk($sformatf("hold_err_m%0d", m), 32'(er), 32'(hold_err[m]));
               end
            end
         end
      end
   end

   task automatic set_req(input int m, input logic v);
      if (m == 0) cpu_req = v; else dma_req = v;
   endtask

   task automatic do_access(input int m, input logic we, input logic [15:0] a,
                            input logic [7:0] wd, input bit drop_early,
                            output int lat, output logic [7:0] lo_mask);
      req_t r;
      int   start;
      bit   got;
      r.we = we; r.addr = a; r.wdata = wd;
      lo_mask = '0; got = 0; lat = -1;
      @(posedge ph1); #1;
      start = cyc;
      if (m == 0) begin
         q_cpu.push_back(r); cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      end else begin
         q_dma.push_back(r); dma_we = we; dma_addr = a; dma_wdata = wd;
      end
      set_req(m, 1'b1);
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge ph1);
         if (i < 8 && !mem_rw_sel) lo_mask[i] = 1'b1;
         if ((m == 0 && cpu_ack) || (m == 1 && dma_ack)) begin
            got = 1;
            lat = cyc - start;
         end else if (drop_early && i == 1) begin
            set_req(m, 1'b0);
            if (m == 0) begin cpu_addr = ~cpu_addr; cpu_wdata = ~cpu_wdata; end
            else        begin dma_addr = ~dma_addr; dma_wdata = ~dma_wdata; end
         end
      end
      set_req(m, 1'b0);
      if (!got) begin
         checks++; errors++;
         $display("FAIL ack_timeout master=%0d actual=no_ack required=ack", m);
      end
   endtask

   task automatic rand_master(input int m, input int n);
      int          lat, sel;
      logic [7:0]  msk;
      logic [15:0] a;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge ph1);
         sel = $urandom_range(0, 9);
         if (sel < 6)      a = {4'h0, 8'h00, 4'($urandom_range(0, 15))};
         else if (sel < 9) a = {4'hF, 12'($urandom)};
         else              a = {4'($urandom_range(1, 14)), 12'($urandom)};
         do_access(m, 1'($urandom_range(0, 1)), a, 8'($urandom), 1'b0, lat, msk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int         lat, start, na, nc, nd;
      logic [7:0] msk;
      bit         got;

      for (int i = 0; i < 4096; i++) begin
         phys_ram[i] = 8'($urandom);
         ref_ram[i]  = phys_ram[i];
      end
      phys_ram[12'h040] = 8'h11;
      ref_ram[12'h040]  = 8'h11;

      // Reset held with a pending CPU read.
      reset_b = 1'b0;
      cpu_we = 1'b0; cpu_addr = 16'hF005; cpu_req = 1'b1;
      q_cpu.push_back('{we: 1'b0, addr: 16'hF005, wdata: 8'h00});
      repeat (3) @(posedge ph1);
      #1;
      chk("rst_rw_sel", 32'(mem_rw_sel), 1);
      chk("rst_oe", 32'(mem_wdata_oe), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_mem_addr", 32'(mem_address), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      @(posedge ph1); #1;
      start = cyc; reset_b = 1'b1; got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge ph1);
         if (cpu_ack) begin got = 1; chk("rst_release_latency", cyc - start, 2); end
      end
      cpu_req = 1'b0;
      if (!got) chk("rst_release_ack", 0, 1);

      // CPU write then read back.
      do_access(0, 1'b1, 16'h0123, 8'h5A, 1'b0, lat, msk);
      chk("wr_latency", lat, 2);
      chk("wr_rw_sel_issue_only", 32'(msk), 32'h02);
      chk("wr_err", 32'(cpu_err), 0);
      do_access(0, 1'b0, 16'h0123, 8'h00, 1'b0, lat, msk);
      chk("rd_latency", lat, 2);
      chk("rd_rw_sel_high", 32'(msk), 0);
      chk("rd_0123", 32'(cpu_rdata), 32'h5A);

      // DMA write to ROM is blocked; ROM still reads its contents.
      do_access(1, 1'b1, 16'hF000, 8'hAA, 1'b0, lat, msk);
      chk("rom_wr_rw_sel", 32'(msk), 0);
      chk("rom_wr_err", 32'(dma_err), 1);
      do_access(1, 1'b0, 16'hF000, 8'h00, 1'b0, lat, msk);
      chk("rom_rd_data", 32'(dma_rdata), 32'(rom_val(16'hF000)));
      chk("rom_rd_err", 32'(dma_err), 0);

      // Contention: both held from the same cycle, two accesses each.
      ack_m.delete(); ack_c.delete();
      @(posedge ph1); #1;
      q_cpu.push_back('{we: 1'b0, addr: 16'hFFFC, wdata: 8'h00});
      q_cpu.push_back('{we: 1'b0, addr: 16'hFFFC, wdata: 8'h00});
      q_dma.push_back('{we: 1'b0, addr: 16'h0010, wdata: 8'h00});
      q_dma.push_back('{we: 1'b0, addr: 16'h0010, wdata: 8'h00});
      cpu_we = 1'b0; cpu_addr = 16'hFFFC; dma_we = 1'b0; dma_addr = 16'h0010;
      cpu_req = 1'b1; dma_req = 1'b1;
      nc = 0; nd = 0;
      for (int i = 0; i < 40 && (nc < 2 || nd < 2); i++) begin
         @(negedge ph1);
         if (cpu_ack) begin nc++; if (nc == 2) cpu_req = 1'b0; end
         if (dma_ack) begin nd++; if (nd == 2) dma_req = 1'b0; end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      @(posedge ph1); #1;
      na = ack_m.size();
      chk("alt_ack_count", na, 4);
      if (na == 4) begin
         chk("alt_order0", ack_m[0], 0);
         chk("alt_order1", ack_m[1], 1);
         chk("alt_order2", ack_m[2], 0);
         chk("alt_order3", ack_m[3], 1);
         for (int i = 1; i < 4; i++) chk("alt_spacing", ack_c[i] - ack_c[i-1], 3);
      end

      // Unmapped read.
      do_access(0, 1'b0, 16'h8000, 8'h00, 1'b0, lat, msk);
      chk("unmapped_rdata", 32'(cpu_rdata), 0);
      chk("unmapped_err", 32'(cpu_err), 1);

      // Request dropped and address changed right after grant.
      do_access(0, 1'b0, 16'h0123, 8'h00, 1'b1, lat, msk);
      chk("early_drop_latency", lat, 2);
      chk("early_drop_rdata", 32'(cpu_rdata), 32'h5A);

      // Reset during ISSUE of a DMA write.
      ack_m.delete(); ack_c.delete();
      @(posedge ph1); #1;
      dma_we = 1'b1; dma_addr = 16'h0040; dma_wdata = 8'h77; dma_req = 1'b1;
      @(posedge ph1); #2;
      chk("midrst_issue_write", 32'(mem_rw_sel), 0);
      reset_b = 1'b0;
      #1;
      chk("midrst_rw_sel", 32'(mem_rw_sel), 1);
      chk("midrst_oe", 32'(mem_wdata_oe), 0);
      chk("midrst_addr", 32'(mem_address), 0);
      dma_req = 1'b0;
      q_cpu.delete(); q_dma.delete();
      @(posedge ph1); #1;
      reset_b = 1'b1;
      repeat (6) @(negedge ph1);
      chk("midrst_no_ack", ack_m.size(), 0);
      do_access(1, 1'b0, 16'h0040, 8'h00, 1'b0, lat, msk);
      chk("midrst_next_latency", lat, 2);
      chk("midrst_ram_unchanged", 32'(dma_rdata), 32'h11);

      // Randomized traffic from both masters.
      fork
         rand_master(0, 40);
         rand_master(1, 40);
      join

      repeat (3) @(posedge ph1);
      chk("sb_cpu_drained", q_cpu.size(), 0);
      chk("sb_dma_drained", q_dma.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
